// File: rtl/cache_pkg.sv
// Shared cache definitions: geometry, refill FSM states, miss payload and
// address field extraction helpers.
package cache_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned NUM_SETS   = 128;
  localparam int unsigned NUM_WAYS   = 4;
  localparam int unsigned LINE_BYTES = 64;
  localparam int unsigned BEAT_W     = 32;
  localparam int unsigned LINE_W     = LINE_BYTES * 8;
  localparam int unsigned BEATS      = LINE_W / BEAT_W;
  localparam int unsigned OFFSET_W   = $clog2(LINE_BYTES);
  localparam int unsigned INDEX_W    = $clog2(NUM_SETS);
  localparam int unsigned TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned WAY_W      = $clog2(NUM_WAYS);
  localparam int unsigned BEAT_CNT_W = $clog2(BEATS);

  typedef enum logic [2:0] {
    RF_IDLE,
    RF_REQ,
    RF_WAIT,
    RF_FILL,
    RF_REPLAY
  } refill_state_e;

  // Everything needed to replay the original access after the refill.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] addr;
    logic              is_store;
    logic              store_byte;
    logic              from_lsq;
    logic [ADDR_W-1:0] store_data;
  } miss_req_t;

  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] get_offset(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W-1:0];
  endfunction

endpackage

// File: rtl/refill_victim_sel.sv
// Per-set round-robin victim pointer array.
//   rd_index_i  -> rd_way_c   : combinational read of the set's pointer
//   inc_i, inc_index_i        : advance that set's pointer (wraps mod NUM_WAYS)
//   rstn                      : synchronous, active-low; clears every pointer
module refill_victim_sel
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic [INDEX_W-1:0] rd_index_i,
  output logic [WAY_W-1:0]   rd_way_c,
  input  logic               inc_i,
  input  logic [INDEX_W-1:0] inc_index_i
);

  logic [WAY_W-1:0] ptr_q [NUM_SETS];

  // Pointer storage; natural WAY_W-bit overflow gives the wrap.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        ptr_q[s] <= '0;
      end
    end else if (inc_i) begin
      ptr_q[inc_index_i] <= ptr_q[inc_index_i] + WAY_W'(1);
    end
  end

  assign rd_way_c = ptr_q[rd_index_i];

endmodule

// File: rtl/cache_refill_unit.sv
// Blocking miss handler: accepts one miss, reads the line as BEATS sequential
// beats, writes it into the cache with a round-robin victim, then replays the
// original request.
//   miss_*    : miss request from the cache pipeline (accepted in IDLE only)
//   mem_req_* : beat read request, valid/ready handshake
//   mem_rsp_* : beat data, consumed only while waiting for a beat
//   fill_*    : one-cycle line write; payload holds its value between fills
//   replay_*  : captured request returned to the pipeline, valid/ready
//   busy      : refill in progress
module cache_refill_unit
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rstn,
  input  logic                miss_valid,
  output logic                miss_ready,
  input  logic [ADDR_W-1:0]   miss_pc,
  input  logic [ADDR_W-1:0]   miss_addr,
  input  logic                miss_is_store,
  input  logic                miss_store_byte,
  input  logic                miss_from_lsq,
  input  logic [ADDR_W-1:0]   miss_store_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  input  logic                mem_rsp_valid,
  input  logic [BEAT_W-1:0]   mem_rsp_data,
  output logic                fill_valid,
  output logic [INDEX_W-1:0]  fill_index,
  output logic [TAG_W-1:0]    fill_tag,
  output logic [WAY_W-1:0]    fill_way,
  output logic [LINE_W-1:0]   fill_data,
  output logic                replay_valid,
  input  logic                replay_ready,
  output logic [ADDR_W-1:0]   replay_pc,
  output logic [ADDR_W-1:0]   replay_addr,
  output logic [ADDR_W-1:0]   replay_store_data,
  output logic                replay_is_store,
  output logic                replay_store_byte,
  output logic                replay_from_lsq,
  output logic                busy
);

  localparam int unsigned WORD_LSB_W = OFFSET_W - BEAT_CNT_W;

  refill_state_e         state_q, state_d;
  logic [BEAT_CNT_W-1:0] beat_q, beat_d;
  logic [LINE_W-1:0]     line_q, line_d;
  miss_req_t             req_q, req_d;
  logic                  fill_load;
  logic                  victim_inc;
  logic [WAY_W-1:0]      victim_way;
  logic [INDEX_W-1:0]    cur_index;

  logic                  miss_ready_q;
  logic                  mem_req_valid_q;
  logic [ADDR_W-1:0]     mem_req_addr_q;
  logic                  fill_valid_q;
  logic [INDEX_W-1:0]    fill_index_q;
  logic [TAG_W-1:0]      fill_tag_q;
  logic [WAY_W-1:0]      fill_way_q;
  logic [LINE_W-1:0]     fill_data_q;
  logic                  replay_valid_q;
  logic                  busy_q;

  assign cur_index = get_index(req_q.addr);

  refill_victim_sel u_victim_sel (
    .clk         (clk),
    .rstn        (rstn),
    .rd_index_i  (cur_index),
    .rd_way_c    (victim_way),
    .inc_i       (victim_inc),
    .inc_index_i (cur_index)
  );

  // Next-state, beat assembly and capture.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    line_d     = line_q;
    req_d      = req_q;
    victim_inc = 1'b0;
    fill_load  = 1'b0;
    unique case (state_q)
      RF_IDLE: begin
        if (miss_valid) begin
          req_d.pc         = miss_pc;
          req_d.addr       = miss_addr;
          req_d.is_store   = miss_is_store;
          req_d.store_byte = miss_store_byte;
          req_d.from_lsq   = miss_from_lsq;
          req_d.store_data = miss_store_data;
          beat_d           = '0;
          state_d          = RF_REQ;
        end
      end
      RF_REQ: begin
        // mem_req_valid is high for the whole of REQ
        if (mem_req_ready) begin
          state_d = RF_WAIT;
        end
      end
      RF_WAIT: begin
        if (mem_rsp_valid) begin
          for (int unsigned b = 0; b < BEATS; b++) begin
            if (beat_q == BEAT_CNT_W'(b)) begin
              line_d[b*BEAT_W +: BEAT_W] = mem_rsp_data;
            end
          end
          if (beat_q == BEAT_CNT_W'(BEATS - 1)) begin
            fill_load = 1'b1;
            state_d   = RF_FILL;
          end else begin
            beat_d  = beat_q + BEAT_CNT_W'(1);
            state_d = RF_REQ;
          end
        end
      end
      RF_FILL: begin
        victim_inc = 1'b1;
        state_d    = RF_REPLAY;
      end
      RF_REPLAY: begin
        if (replay_ready) begin
          state_d = RF_IDLE;
        end
      end
      default: state_d = RF_IDLE;
    endcase
  end

  // State and registered outputs; outputs are decoded from next state so they
  // line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q         <= RF_IDLE;
      beat_q          <= '0;
      line_q          <= '0;
      req_q           <= '0;
      miss_ready_q    <= 1'b1;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      fill_valid_q    <= 1'b0;
      fill_index_q    <= '0;
      fill_tag_q      <= '0;
      fill_way_q      <= '0;
      fill_data_q     <= '0;
      replay_valid_q  <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      beat_q          <= beat_d;
      line_q          <= line_d;
      req_q           <= req_d;
      miss_ready_q    <= (state_d == RF_IDLE);
      mem_req_valid_q <= (state_d == RF_REQ);
      mem_req_addr_q  <= {req_d.addr[ADDR_W-1:OFFSET_W], beat_d, WORD_LSB_W'(0)};
      fill_valid_q    <= fill_load;
      replay_valid_q  <= (state_d == RF_REPLAY);
      busy_q          <= (state_d != RF_IDLE);
      // Victim is read before this set's pointer advances in FILL.
      if (fill_load) begin
        fill_index_q <= cur_index;
        fill_tag_q   <= get_tag(req_q.addr);
        fill_way_q   <= victim_way;
        fill_data_q  <= line_d;
      end
    end
  end

  assign miss_ready        = miss_ready_q;
  assign mem_req_valid     = mem_req_valid_q;
  assign mem_req_addr      = mem_req_addr_q;
  assign fill_valid        = fill_valid_q;
  assign fill_index        = fill_index_q;
  assign fill_tag          = fill_tag_q;
  assign fill_way          = fill_way_q;
  assign fill_data         = fill_data_q;
  assign replay_valid      = replay_valid_q;
  assign replay_pc         = req_q.pc;
  assign replay_addr       = req_q.addr;
  assign replay_store_data = req_q.store_data;
  assign replay_is_store   = req_q.is_store;
  assign replay_store_byte = req_q.store_byte;
  assign replay_from_lsq   = req_q.from_lsq;
  assign busy              = busy_q;

endmodule

// File: tb/tb_cache_refill_unit.sv
// Bench for cache_refill_unit: directed scenarios plus randomized misses,
// checked against a line/victim model and a memory responder.
module tb_cache_refill_unit;

  logic         clk;
  logic         rstn;
  logic         miss_valid;
  logic         miss_ready;
  logic [31:0]  miss_pc;
  logic [31:0]  miss_addr;
  logic         miss_is_store;
  logic         miss_store_byte;
  logic         miss_from_lsq;
  logic [31:0]  miss_store_data;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [31:0]  mem_req_addr;
  logic         mem_rsp_valid;
  logic [31:0]  mem_rsp_data;
  logic         fill_valid;
  logic [6:0]   fill_index;
  logic [18:0]  fill_tag;
  logic [1:0]   fill_way;
  logic [511:0] fill_data;
  logic         replay_valid;
  logic         replay_ready;
  logic [31:0]  replay_pc;
  logic [31:0]  replay_addr;
  logic [31:0]  replay_store_data;
  logic         replay_is_store;
  logic         replay_store_byte;
  logic         replay_from_lsq;
  logic         busy;

  cache_refill_unit dut (
    .clk               (clk),
    .rstn              (rstn),
    .miss_valid        (miss_valid),
    .miss_ready        (miss_ready),
    .miss_pc           (miss_pc),
    .miss_addr         (miss_addr),
    .miss_is_store     (miss_is_store),
    .miss_store_byte   (miss_store_byte),
    .miss_from_lsq     (miss_from_lsq),
    .miss_store_data   (miss_store_data),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ready     (mem_req_ready),
    .mem_req_addr      (mem_req_addr),
    .mem_rsp_valid     (mem_rsp_valid),
    .mem_rsp_data      (mem_rsp_data),
    .fill_valid        (fill_valid),
    .fill_index        (fill_index),
    .fill_tag          (fill_tag),
    .fill_way          (fill_way),
    .fill_data         (fill_data),
    .replay_valid      (replay_valid),
    .replay_ready      (replay_ready),
    .replay_pc         (replay_pc),
    .replay_addr       (replay_addr),
    .replay_store_data (replay_store_data),
    .replay_is_store   (replay_is_store),
    .replay_store_byte (replay_store_byte),
    .replay_from_lsq   (replay_from_lsq),
    .busy              (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_checks = 0;
  int          n_errors = 0;

  // Memory model and responder knobs
  logic [31:0] mem_salt = 32'h0;
  logic [31:0] cur_base = 32'h0;
  int          hs_cnt = 0;
  int          stall_beat = -1;
  int          stall_left = 0;
  bit          rand_ready = 1'b0;
  bit          rand_dly = 1'b0;
  bit          spur_en = 1'b0;
  bit          hold_en = 1'b0;
  int          hold_beat = 7;

  // Victim model: fills seen per set since reset
  int          ptr_model [128];
  logic [1:0]  last_way;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ mem_salt;
  endfunction

  // Memory responder: decides ready/response for the coming cycle at each negedge.
  initial begin : mem_responder
    bit          pending;
    int          rsp_wait;
    logic [31:0] rsp_addr;
    logic [31:0] exp_addr;
    logic [3:0]  bi;
    pending       = 1'b0;
    rsp_wait      = 0;
    rsp_addr      = 32'h0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'h0;
      if (rstn !== 1'b1) begin
        pending = 1'b0;
      end else if (pending) begin
        if (rsp_wait == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = mem_word(rsp_addr);
          pending       = 1'b0;
        end else begin
          rsp_wait--;
        end
      end else if (mem_req_valid === 1'b1) begin
        bi       = 4'(hs_cnt);
        exp_addr = {cur_base[31:6], bi, 2'b00};
        chk("beat_addr", 512'(mem_req_addr), 512'(exp_addr));
        if (stall_left > 0 && hs_cnt == stall_beat) begin
          stall_left--;
        end else if (rand_ready && $urandom_range(3) == 0) begin
          mem_req_ready = 1'b0;
        end else begin
          mem_req_ready = 1'b1;
        end
        if (mem_req_ready) begin
          if (!(hold_en && hs_cnt == hold_beat)) begin
            pending  = 1'b1;
            rsp_addr = mem_req_addr;
            rsp_wait = rand_dly ? int'($urandom_range(2)) : 0;
          end
          hs_cnt++;
        end
        // A response while requesting must be ignored by the unit.
        if (spur_en && $urandom_range(1) == 1) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = 32'hDEAD;
        end
      end else if (miss_ready === 1'b1 && spur_en && $urandom_range(1) == 1) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDEAD;
      end
    end
  end

  // Waits for miss_ready and hands one miss over; returns in cycle 1 of the refill.
  task automatic issue_miss(input logic [31:0] addr, input logic [31:0] pc,
                            input logic [31:0] sdata, input bit is_st,
                            input bit sb, input bit lsq);
    int w;
    w = 0;
    while (miss_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("miss_ready_idle", 512'(miss_ready), 512'(1));
    cur_base        = addr;
    hs_cnt          = 0;
    miss_addr       = addr;
    miss_pc         = pc;
    miss_store_data = sdata;
    miss_is_store   = is_st;
    miss_store_byte = sb;
    miss_from_lsq   = lsq;
    miss_valid      = 1'b1;
    @(negedge clk);
    miss_valid = 1'b0;
    chk("busy_after_accept", 512'(busy), 512'(1));
    chk("miss_ready_busy", 512'(miss_ready), 512'(0));
  endtask

  // Full refill with checks of fill payload, latency and replay handshake.
  task automatic do_miss(input logic [31:0] addr, input logic [31:0] pc,
                         input logic [31:0] sdata, input bit is_st, input bit sb,
                         input bit lsq, input int exp_cyc, input int rp_stall);
    logic [511:0] exp_line;
    logic [3:0]   bi;
    int           idx;
    int           cyc;
    for (int b = 0; b < 16; b++) begin
      bi = 4'(b);
      exp_line[b*32 +: 32] = mem_word({addr[31:6], bi, 2'b00});
    end
    idx = int'(addr[12:6]);
    issue_miss(addr, pc, sdata, is_st, sb, lsq);
    cyc = 1;
    while (fill_valid !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("fill_seen", 512'(fill_valid), 512'(1));
    if (fill_valid === 1'b1) begin
      if (exp_cyc > 0) chk("fill_cycle", 512'(cyc), 512'(exp_cyc));
      chk("fill_index", 512'(fill_index), 512'(addr[12:6]));
      chk("fill_tag", 512'(fill_tag), 512'(addr[31:13]));
      chk("fill_way", 512'(fill_way), 512'(ptr_model[idx] % 4));
      chk("fill_data", fill_data, exp_line);
      chk("beats_fetched", 512'(hs_cnt), 512'(16));
      chk("replay_before_fill", 512'(replay_valid), 512'(0));
      last_way = fill_way;
      ptr_model[idx] = (ptr_model[idx] + 1) % 4;
      @(negedge clk);
      chk("fill_one_cycle", 512'(fill_valid), 512'(0));
      chk("replay_valid", 512'(replay_valid), 512'(1));
      chk("replay_addr", 512'(replay_addr), 512'(addr));
      chk("replay_pc", 512'(replay_pc), 512'(pc));
      chk("replay_data", 512'(replay_store_data), 512'(sdata));
      chk("replay_is_store", 512'(replay_is_store), 512'(is_st));
      chk("replay_store_byte", 512'(replay_store_byte), 512'(sb));
      chk("replay_from_lsq", 512'(replay_from_lsq), 512'(lsq));
      // A competing miss during the stall must be ignored.
      for (int k = 0; k < rp_stall; k++) begin
        replay_ready = 1'b0;
        miss_valid   = 1'b1;
        miss_addr    = addr ^ 32'h0001_0040;
        @(negedge clk);
        chk("replay_held", 512'(replay_valid), 512'(1));
        chk("replay_addr_held", 512'(replay_addr), 512'(addr));
        chk("miss_ready_in_replay", 512'(miss_ready), 512'(0));
      end
      miss_valid   = 1'b0;
      replay_ready = 1'b1;
      @(negedge clk);
      replay_ready = 1'b0;
      chk("replay_done", 512'(replay_valid), 512'(0));
      chk("miss_ready_after", 512'(miss_ready), 512'(1));
      chk("busy_after", 512'(busy), 512'(0));
    end
  endtask

  function automatic logic [31:0] mk_addr(input int tag, input int idx, input int off);
    return (32'(tag) << 13) | (32'(idx) << 6) | 32'(off);
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] a;
    int          ways_exp [5];
    int          cyc;
    rstn            = 1'b0;
    miss_valid      = 1'b0;
    miss_pc         = 32'h0;
    miss_addr       = 32'h0;
    miss_is_store   = 1'b0;
    miss_store_byte = 1'b0;
    miss_from_lsq   = 1'b0;
    miss_store_data = 32'h0;
    replay_ready    = 1'b0;
    for (int s = 0; s < 128; s++) ptr_model[s] = 0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_miss_ready", 512'(miss_ready), 512'(1));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_mem_req_valid", 512'(mem_req_valid), 512'(0));
    chk("rst_fill_valid", 512'(fill_valid), 512'(0));
    chk("rst_fill_data", fill_data, 512'(0));
    chk("rst_replay_valid", 512'(replay_valid), 512'(0));
    chk("rst_replay_addr", 512'(replay_addr), 512'(0));
    rstn = 1'b1;
    @(negedge clk);

    // Load miss, memory returns the beat address
    do_miss(32'h0000_2044, 32'h0000_1000, 32'h0, 1'b0, 1'b0, 1'b0, 33, 0);
    chk("t1_way", 512'(last_way), 512'(0));
    chk("t1_word0", 512'(fill_data[31:0]), 512'(32'h2040));
    chk("t1_word15", 512'(fill_data[511:480]), 512'(32'h207C));

    // Round robin on index 1, with an index-2 miss in between
    ways_exp = '{1, 2, 3, 0, 0};
    do_miss(mk_addr(2, 1, 0), 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 33, 0);
    chk("rr_way_t2", 512'(last_way), 512'(ways_exp[0]));
    do_miss(mk_addr(3, 1, 8), 32'h14, 32'h0, 1'b0, 1'b0, 1'b0, 33, 0);
    chk("rr_way_t3", 512'(last_way), 512'(ways_exp[1]));
    do_miss(mk_addr(9, 2, 4), 32'h18, 32'h0, 1'b0, 1'b0, 1'b0, 33, 0);
    chk("rr_way_idx2", 512'(last_way), 512'(ways_exp[4]));
    do_miss(mk_addr(4, 1, 0), 32'h1C, 32'h0, 1'b0, 1'b0, 1'b0, 33, 0);
    chk("rr_way_t4", 512'(last_way), 512'(ways_exp[2]));
    do_miss(mk_addr(5, 1, 0), 32'h20, 32'h0, 1'b0, 1'b0, 1'b0, 33, 0);
    chk("rr_way_t5", 512'(last_way), 512'(ways_exp[3]));

    // Byte store miss from the LSQ
    do_miss(32'h0000_4003, 32'h0000_0100, 32'h0000_00AB, 1'b1, 1'b1, 1'b1, 33, 0);
    chk("st_replay_data", 512'(replay_store_data), 512'(32'hAB));
    chk("st_replay_pc", 512'(replay_pc), 512'(32'h100));

    // Memory and replay backpressure
    stall_beat = 5;
    stall_left = 3;
    do_miss(32'h0000_6040, 32'h0000_0200, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 36, 4);
    chk("bp_stall_used", 512'(stall_left), 512'(0));
    stall_beat = -1;

    // Spurious responses outside WAIT
    spur_en = 1'b1;
    do_miss(mk_addr(11, 5, 0), 32'h300, 32'h0, 1'b0, 1'b0, 1'b0, 33, 0);
    spur_en = 1'b0;

    // Reset while waiting for beat 7
    hold_en = 1'b1;
    issue_miss(mk_addr(6, 1, 0), 32'h400, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc = 0;
    while (hs_cnt < 8 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("hold_reached", 512'(hs_cnt), 512'(8));
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("abort_miss_ready", 512'(miss_ready), 512'(1));
    chk("abort_busy", 512'(busy), 512'(0));
    chk("abort_mem_req", 512'(mem_req_valid), 512'(0));
    rstn    = 1'b1;
    hold_en = 1'b0;
    for (int s = 0; s < 128; s++) ptr_model[s] = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_fill", 512'(fill_valid), 512'(0));
      chk("abort_no_replay", 512'(replay_valid), 512'(0));
    end
    do_miss(mk_addr(7, 1, 0), 32'h500, 32'h0, 1'b0, 1'b0, 1'b0, 33, 0);
    chk("post_abort_way", 512'(last_way), 512'(0));

    // Randomized traffic
    rand_ready = 1'b1;
    rand_dly   = 1'b1;
    for (int n = 0; n < 40; n++) begin
      mem_salt = $urandom;
      spur_en  = ($urandom_range(1) == 1);
      a = mk_addr(int'($urandom_range(32'h7FFFF)), int'($urandom_range(3)),
                  int'($urandom_range(63)));
      do_miss(a, $urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)),
              1'($urandom_range(1)), 0, int'($urandom_range(3)));
    end
    spur_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
